// File: rtl/mpkt_expand_ctrl_if.sv
// Packet handshake bundle shared by the upstream and downstream sides of mpkt_expand_ctrl.
// The master drives vld and the packet fields, and the slave drives rdy.
interface mpkt_expand_ctrl_if #(
   parameter int DW = 32
);
   logic          vld;
   logic          rdy;
   logic [1:0]    ptype;
   logic [5:0]    tgt;
   logic [DW-1:0] data;
   logic          last;

   modport master (
      output vld,
      output ptype,
      output tgt,
      output data,
      output last,
      input  rdy
   );

   modport slave (
      input  vld,
      input  ptype,
      input  tgt,
      input  data,
      input  last,
      output rdy
   );
endinterface

// File: rtl/mpkt_expand_ctrl.sv
// Multi-target packet sequencer. When a dead node is configured, it expands row, column and
// broadcast packets into unicast copies that skip the dead node.
// The optional macro MPKT_SKIP_SELF_EN also skips this node's own coordinate during expansion.
module mpkt_expand_ctrl #(
   parameter logic [2:0] LOCAL_X = 3'd0,
   parameter logic [2:0] LOCAL_Y = 3'd0,
   parameter int         DW      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   mpkt_expand_ctrl_if.slave        in_bus,
   mpkt_expand_ctrl_if.master       out_bus,
   input  logic                     pg_en,
   input  logic [5:0]               pg_node,
   output logic                     drop,
   output logic                     busy,
   output logic [6:0]               copy_cnt
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_EXPAND = 2'd2;

   localparam logic [5:0] SELF_NODE = {LOCAL_Y, LOCAL_X};
`ifdef MPKT_SKIP_SELF_EN
   localparam logic SELF_SKIP = 1'b1;
`else
   localparam logic SELF_SKIP = 1'b0;
`endif

   logic [1:0]    state;
   logic [1:0]    held_type;
   logic [5:0]    held_tgt;
   logic [DW-1:0] held_data;
   logic [5:0]    held_pg;
   logic [5:0]    cur;
   logic          drop_q;
   logic [6:0]    cnt_q;

   logic          accept;
   logic [5:0]    n1;
   logic [5:0]    n2;
   logic          cur_skip;
   logic          cur_final;
   logic          exp_last;

   function automatic logic is_skip(input logic [5:0] p, input logic [5:0] pg);
      return (p == pg) || (SELF_SKIP && (p == SELF_NODE));
   endfunction

   function automatic logic is_final(input logic [5:0] p, input logic [1:0] ty);
      case (ty)
         2'b01:   return p[5:3] == 3'd7;
         2'b10:   return p[2:0] == 3'd7;
         default: return p == 6'd63;
      endcase
   endfunction

   function automatic logic [5:0] next_pos(input logic [5:0] p, input logic [1:0] ty);
      case (ty)
         2'b01:   return {p[5:3] + 3'd1, p[2:0]};
         2'b10:   return {p[5:3], p[2:0] + 3'd1};
         default: return p + 6'd1;
      endcase
   endfunction

   assign in_bus.rdy = (state == ST_IDLE) || ((state == ST_HOLD) && out_bus.rdy);
   assign accept     = in_bus.vld && in_bus.rdy;
   assign busy       = (state != ST_IDLE);
   assign drop       = drop_q;
   assign copy_cnt   = cnt_q;

   assign n1        = next_pos(cur, held_type);
   assign n2        = next_pos(n1, held_type);
   assign cur_skip  = is_skip(cur, held_pg);
   assign cur_final = is_final(cur, held_type);
   // Only the dead node and optionally this node can be skipped, so two positions of lookahead are enough.
   assign exp_last  = cur_final ||
                      (is_skip(n1, held_pg) &&
                       (is_final(n1, held_type) || (is_skip(n2, held_pg) && is_final(n2, held_type))));

   always_comb begin
      out_bus.vld   = 1'b0;
      out_bus.ptype = 2'b00;
      out_bus.tgt   = 6'd0;
      out_bus.data  = '0;
      out_bus.last  = 1'b0;
      case (state)
         ST_HOLD: begin
            out_bus.vld   = 1'b1;
            out_bus.ptype = held_type;
            out_bus.tgt   = held_tgt;
            out_bus.data  = held_data;
            out_bus.last  = 1'b1;
         end
         ST_EXPAND: begin
            out_bus.vld   = !cur_skip;
            out_bus.tgt   = cur;
            out_bus.data  = held_data;
            out_bus.last  = !cur_skip && exp_last;
         end
         default: ;
      endcase
   end

   // An accept in HOLD always coincides with the handoff, because in_rdy needs out_rdy there.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         held_type <= 2'b00;
         held_tgt  <= 6'd0;
         held_data <= '0;
         held_pg   <= 6'd0;
         cur       <= 6'd0;
         drop_q    <= 1'b0;
         cnt_q     <= 7'd0;
      end else begin
         drop_q <= 1'b0;
         if (accept) begin
            cnt_q     <= 7'd0;
            held_type <= in_bus.ptype;
            held_tgt  <= in_bus.tgt;
            held_data <= in_bus.data;
            held_pg   <= pg_node;
            if (!pg_en || ((in_bus.ptype == 2'b00) && (in_bus.tgt != pg_node))) begin
               state <= ST_HOLD;
            end else if (in_bus.ptype == 2'b00) begin
               drop_q <= 1'b1;
               state  <= ST_IDLE;
            end else begin
               state <= ST_EXPAND;
               case (in_bus.ptype)
                  2'b01:   cur <= {3'd0, in_bus.tgt[2:0]};
                  2'b10:   cur <= {in_bus.tgt[5:3], 3'd0};
                  default: cur <= 6'd0;
               endcase
            end
         end else begin
            case (state)
               ST_HOLD: begin
                  if (out_bus.rdy) begin
                     state <= ST_IDLE;
                     cnt_q <= cnt_q + 7'd1;
                  end
               end
               ST_EXPAND: begin
                  if (cur_skip || out_bus.rdy) begin
                     if (!cur_skip) begin
                        cnt_q <= cnt_q + 7'd1;
                     end
                     if (cur_final) begin
                        state <= ST_IDLE;
                        cur   <= 6'd0;
                     end else begin
                        cur <= n1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
